// File: rtl/cmp_pkg.sv
// cmp_pkg: comparator result codes, run-FSM state enum and code-to-state mapping
package cmp_pkg;
  localparam logic [1:0] RES_EQ = 2'b00, RES_GT = 2'b01, RES_LT = 2'b10, RES_BAD = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN_GT, RUN_LT, RUN_EQ} run_state_t;
  function automatic run_state_t res2state(logic [1:0] r);
    return r == RES_GT ? RUN_GT : r == RES_LT ? RUN_LT : RUN_EQ;
  endfunction
endpackage

// File: rtl/cmp_stream_monitor_if.sv
// cmp_stream_monitor_if: monitor bus; slave sees in_valid/in_res/clr/evt_ready in, cnt_*/run_len/last_res/evt_*/err out
interface cmp_stream_monitor_if #(parameter int CNT_W = 8);
  logic in_valid;
  logic [1:0] in_res;
  logic clr;
  logic [CNT_W-1:0] cnt_gt, cnt_lt, cnt_eq;
  logic [3:0] run_len;
  logic [1:0] last_res;
  logic evt_valid;
  logic [1:0] evt_code;
  logic evt_ready;
  logic evt_ovf;
  logic err;
  modport master(output in_valid, in_res, clr, evt_ready,
                 input cnt_gt, cnt_lt, cnt_eq, run_len, last_res, evt_valid, evt_code, evt_ovf, err);
  modport slave(input in_valid, in_res, clr, evt_ready,
                output cnt_gt, cnt_lt, cnt_eq, run_len, last_res, evt_valid, evt_code, evt_ovf, err);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones; ports clk, rst, clr, inc in, q out
module sat_counter #(parameter int W = 8) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst || clr) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/cmp_stream_monitor.sv
// cmp_stream_monitor: counts comparator results and flags runs of STREAK_LEN; ports clk, rst, bus (slave); CMP_MON_ERR_EN enables sticky err on code 11
module cmp_stream_monitor import cmp_pkg::*; #(
  parameter int CNT_W = 8,
  parameter int STREAK_LEN = 4
) (
  input logic clk,
  input logic rst,
  cmp_stream_monitor_if.slave bus
);
  run_state_t state, state_n;
  logic [3:0] run_n;
  logic [1:0] last_n, code_n;
  logic valid_n, ovf_n, acc, new_evt;
  logic [CNT_W-1:0] c_gt, c_lt, c_eq;
  assign acc = bus.in_valid && !bus.clr && bus.in_res != RES_BAD;
  sat_counter #(.W(CNT_W)) u_gt (.clk(clk), .rst(rst), .clr(bus.clr), .inc(acc && bus.in_res == RES_GT), .q(c_gt));
  sat_counter #(.W(CNT_W)) u_lt (.clk(clk), .rst(rst), .clr(bus.clr), .inc(acc && bus.in_res == RES_LT), .q(c_lt));
  sat_counter #(.W(CNT_W)) u_eq (.clk(clk), .rst(rst), .clr(bus.clr), .inc(acc && bus.in_res == RES_EQ), .q(c_eq));
  assign bus.cnt_gt = c_gt;
  assign bus.cnt_lt = c_lt;
  assign bus.cnt_eq = c_eq;
  always_comb begin
    state_n = bus.clr ? IDLE : acc ? res2state(bus.in_res) : state;
    run_n = bus.clr ? 4'd0 : !acc ? bus.run_len : state != res2state(bus.in_res) ? 4'd1 :
            bus.run_len == 4'd15 ? 4'd15 : bus.run_len + 4'd1;
    last_n = acc ? bus.in_res : bus.last_res;
    // a run held at 15 keeps run_n unchanged, so it cannot re-fire
    new_evt = acc && run_n == 4'(STREAK_LEN) && run_n != bus.run_len;
    valid_n = new_evt || (bus.evt_valid && !bus.evt_ready);
    code_n = new_evt && (!bus.evt_valid || bus.evt_ready) ? bus.in_res : bus.evt_code;
    ovf_n = !bus.clr && (bus.evt_ovf || (new_evt && bus.evt_valid && !bus.evt_ready));
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      bus.run_len <= '0;
      bus.last_res <= RES_EQ;
      bus.evt_valid <= 1'b0;
      bus.evt_code <= RES_EQ;
      bus.evt_ovf <= 1'b0;
    end else begin
      state <= state_n;
      bus.run_len <= run_n;
      bus.last_res <= last_n;
      bus.evt_valid <= valid_n;
      bus.evt_code <= code_n;
      bus.evt_ovf <= ovf_n;
    end
`ifdef CMP_MON_ERR_EN
  always_ff @(posedge clk)
    bus.err <= !rst && !bus.clr && (bus.err || (bus.in_valid && bus.in_res == RES_BAD));
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_cmp_stream_monitor.sv
// tb_cmp_stream_monitor: directed and random stimulus against a behavioural model of the monitor
module tb_cmp_stream_monitor;
  localparam int SL = 4;
`ifdef CMP_MON_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, v = 1'b0, c = 1'b0, rdy = 1'b1;
  logic [1:0] res = 2'b00, prev = 2'b01;
  always #5 clk = ~clk;
  cmp_stream_monitor_if #(.CNT_W(8)) b0();
  cmp_stream_monitor_if #(.CNT_W(2)) b1();
  assign b0.in_valid = v;
  assign b0.in_res = res;
  assign b0.clr = c;
  assign b0.evt_ready = rdy;
  assign b1.in_valid = v;
  assign b1.in_res = res;
  assign b1.clr = c;
  assign b1.evt_ready = rdy;
  cmp_stream_monitor #(.CNT_W(8), .STREAK_LEN(SL)) d0 (.clk(clk), .rst(rst), .bus(b0));
  cmp_stream_monitor #(.CNT_W(2), .STREAK_LEN(SL)) d1 (.clk(clk), .rst(rst), .bus(b1));
  int n_chk = 0, n_err = 0;
  bit chk_on = 1'b0;
  int m_cnt[4], m_cnt2[4];
  int m_streak = 0, m_code = 0, m_last = 0, m_ev_v = 0, m_ev_c = 0, m_ovf = 0, m_err = 0;
  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // model: counters are plain saturating integers, the run is an unbounded streak length
  task automatic step();
    int hs, nev;
    hs = m_ev_v != 0 && rdy;
    nev = 0;
    if (rst) begin
      m_cnt = '{default: 0};
      m_cnt2 = '{default: 0};
      m_streak = 0; m_code = 0; m_last = 0; m_ev_v = 0; m_ev_c = 0; m_ovf = 0; m_err = 0;
      return;
    end
    if (c) begin
      m_cnt = '{default: 0};
      m_cnt2 = '{default: 0};
      m_streak = 0; m_ovf = 0; m_err = 0;
    end else if (v && res == 2'b11) begin
      if (ERR_EN) m_err = 1;
    end else if (v) begin
      m_cnt[res] = m_cnt[res] < 255 ? m_cnt[res] + 1 : 255;
      m_cnt2[res] = m_cnt2[res] < 3 ? m_cnt2[res] + 1 : 3;
      m_streak = (m_streak > 0 && int'(res) == m_code) ? m_streak + 1 : 1;
      m_code = res;
      m_last = res;
      nev = m_streak == SL;
    end
    if (nev != 0) begin
      if (m_ev_v == 0 || hs != 0) begin m_ev_v = 1; m_ev_c = res; end
      else m_ovf = 1;
    end else if (hs != 0) m_ev_v = 0;
  endtask
  task automatic tick(bit iv, logic [1:0] ir, bit ic = 1'b0, bit irdy = 1'b1, bit irst = 1'b0);
    v = iv; res = ir; c = ic; rdy = irdy; rst = irst;
    @(posedge clk);
    step();
    #1;
  endtask
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("cnt_gt", b0.cnt_gt, m_cnt[1]);
      chk("cnt_lt", b0.cnt_lt, m_cnt[2]);
      chk("cnt_eq", b0.cnt_eq, m_cnt[0]);
      chk("run_len", b0.run_len, m_streak > 15 ? 15 : m_streak);
      chk("last_res", b0.last_res, m_last);
      chk("evt_valid", b0.evt_valid, m_ev_v);
      if (m_ev_v != 0) chk("evt_code", b0.evt_code, m_ev_c);
      chk("evt_ovf", b0.evt_ovf, m_ovf);
      chk("err", b0.err, m_err);
      chk("w2_cnt_gt", b1.cnt_gt, m_cnt2[1]);
      chk("w2_cnt_lt", b1.cnt_lt, m_cnt2[2]);
      chk("w2_cnt_eq", b1.cnt_eq, m_cnt2[0]);
      chk("w2_evt_valid", b1.evt_valid, m_ev_v);
    end
  end
  initial begin
    tick(0, 2'b00, 0, 1, 1);
    tick(0, 2'b00, 0, 1, 1);
    chk_on = 1'b1;
    chk("rst_cnt_gt", b0.cnt_gt, 0);
    chk("rst_run_len", b0.run_len, 0);
    chk("rst_evt_valid", b0.evt_valid, 0);
    for (int i = 0; i < 3; i++) tick(1, 2'b01);
    chk("gt3_evt_valid", b0.evt_valid, 0);
    tick(1, 2'b01);
    chk("gt4_cnt_gt", b0.cnt_gt, 4);
    chk("gt4_model_cnt", m_cnt[1], 4);
    chk("gt4_run_len", b0.run_len, 4);
    chk("gt4_evt_valid", b0.evt_valid, 1);
    chk("gt4_evt_code", b0.evt_code, 1);
    chk("w2_gt4_cnt", b1.cnt_gt, 3);
    tick(0, 2'b00);
    chk("pulse_done", b0.evt_valid, 0);
    tick(1, 2'b01);
    chk("w2_gt5_cnt", b1.cnt_gt, 3);
    chk("gt5_no_refire", b0.evt_valid, 0);
    tick(0, 2'b00, 0, 0, 1);
    for (int i = 0; i < 4; i++) tick(1, 2'b00, 0, 0);
    chk("eq4_evt_valid", b0.evt_valid, 1);
    chk("eq4_evt_code", b0.evt_code, 0);
    for (int i = 0; i < 4; i++) tick(1, 2'b10, 0, 0);
    chk("lt4_evt_code", b0.evt_code, 0);
    chk("lt4_evt_ovf", b0.evt_ovf, 1);
    chk("lt4_model_ovf", m_ovf, 1);
    tick(0, 2'b00, 0, 1, 1);
    tick(1, 2'b01); tick(1, 2'b01); tick(1, 2'b11); tick(1, 2'b01); tick(1, 2'b01);
    chk("bad_err", b0.err, ERR_EN);
    chk("bad_run_len", b0.run_len, 4);
    chk("bad_evt_valid", b0.evt_valid, 1);
    chk("bad_evt_code", b0.evt_code, 1);
    tick(0, 2'b00, 0, 1, 1);
    tick(1, 2'b10); tick(1, 2'b10);
    tick(1, 2'b10, 0, 1, 1);
    tick(1, 2'b10);
    chk("rstmid_run_len", b0.run_len, 1);
    chk("rstmid_cnt_lt", b0.cnt_lt, 1);
    chk("rstmid_evt_valid", b0.evt_valid, 0);
    tick(1, 2'b01); tick(1, 2'b01);
    tick(1, 2'b01, 1);
    chk("clr_cnt_gt", b0.cnt_gt, 0);
    chk("clr_cnt_lt", b0.cnt_lt, 0);
    chk("clr_run_len", b0.run_len, 0);
    tick(1, 2'b01);
    chk("clr_idle_run", b0.run_len, 1);
    for (int i = 0; i < 20; i++) tick(1, 2'b00);
    chk("sat_run_len", b0.run_len, 15);
    chk("sat_cnt_eq", b0.cnt_eq, 20);
    for (int i = 0; i < 3000; i++) begin
      prev = ($urandom_range(0, 99) < 60) ? prev : 2'($urandom_range(0, 3));
      tick($urandom_range(0, 99) < 75, prev, $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 50, $urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
